step_ctrl: RTL

Run/step controller for the miniRISC processor on the FPGA board. Generates a single-cycle clock-enable pulse that advances the processor one instruction: free-running at a divided rate, or one instruction per debounced push-button press. Adds a PC breakpoint and a terminal halt state. Sits between the board inputs (button, switches) and the processor core, replacing the free-running divided clock with a clock enable on the board clock.

---
 rtl/step_ctrl_pkg.sv | 15 +
 rtl/step_ctrl_if.sv | 26 ++
 rtl/debouncer.sv | 60 ++++++
 rtl/step_ctrl.sv | 132 +++++++++++++
 4 files changed

// File: rtl/step_ctrl_pkg.sv
// Shared definitions for the miniRISC run/step controller.
package step_ctrl_pkg;

    // Default program-counter width.
    localparam int unsigned PC_W_DEF = 10;

    // Controller state. The numeric values are visible on the state output.
    typedef enum logic [1:0] {
        STOPPED = 2'd0,
        RUN     = 2'd1,
        BREAK   = 2'd2,
        HALTED  = 2'd3
    } state_t;

endpackage

// File: rtl/step_ctrl_if.sv
// Processor-side link: clock enable out, PC and halt status back.
interface step_ctrl_if
    import step_ctrl_pkg::*;
#(
    parameter int unsigned PC_W = PC_W_DEF
) ();

    logic [PC_W-1:0] pc;
    logic            halted_in;
    logic            cpu_ce;

    // Controller side.
    modport master (
        output cpu_ce,
        input  pc,
        input  halted_in
    );

    // Processor side.
    modport slave (
        input  cpu_ce,
        output pc,
        output halted_in
    );

endinterface

// File: rtl/debouncer.sv
// Push-button conditioning: 2-flop synchroniser, stability counter,
// debounced level and a one-cycle press pulse on its rising edge.
module debouncer
    import step_ctrl_pkg::*;
#(
    parameter int unsigned DEBOUNCE = 1_000_000
) (
    input  logic clk,
    input  logic rst,
    input  logic button,
    output logic press
);

    localparam int unsigned CW = $clog2(DEBOUNCE + 1);
    localparam logic [CW-1:0] CNT_MAX = CW'(DEBOUNCE);

    logic          sync_1;
    logic          sync_2;
    logic [CW-1:0] cnt;
    logic          db;
    logic          db_q;

    // Bring the raw button into the clock domain.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            sync_1 <= 1'b0;
            sync_2 <= 1'b0;
        end else begin
            sync_1 <= button;
            sync_2 <= sync_1;
        end
    end

    // Accept a new level once it has differed from db for DEBOUNCE cycles.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            cnt <= '0;
            db  <= 1'b0;
        end else if (sync_2 == db) begin
            cnt <= '0;
        end else if (cnt == CNT_MAX) begin
            db  <= sync_2;
            cnt <= '0;
        end else begin
            cnt <= cnt + 1'b1;
        end
    end

    // Registered pulse on the rising edge of the debounced level.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            db_q  <= 1'b0;
            press <= 1'b0;
        end else begin
            db_q  <= db;
            press <= db & ~db_q;
        end
    end

endmodule

// File: rtl/step_ctrl.sv
// Run/step controller: turns board switches and the step button into a
// single-cycle processor clock enable, with PC breakpoint and halt state.
module step_ctrl
    import step_ctrl_pkg::*;
#(
    parameter int unsigned DIV      = 50_000_000,
    parameter int unsigned DEBOUNCE = 1_000_000,
    parameter int unsigned PC_W     = PC_W_DEF
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             button,
    input  logic             run_sw,
    input  logic             bp_en,
    input  logic [PC_W-1:0]  bp_addr,
    step_ctrl_if.master      cpu,
    output logic [1:0]       state,
    output logic [15:0]      step_count
);

    localparam int unsigned DW = $clog2(DIV);
    localparam logic [DW-1:0] DIV_LAST = DW'(DIV - 1);

    state_t          state_q;
    state_t          state_nxt;
    logic            ce_q;
    logic            ce_nxt;
    logic [15:0]     step_count_q;
    logic [DW-1:0]   div_q;
    logic            tick_q;
    logic            run_1;
    logic            run_s;
    logic            press;
    logic            stay_run;

    debouncer #(
        .DEBOUNCE(DEBOUNCE)
    ) u_debouncer (
        .clk    (clk),
        .rst    (rst),
        .button (button),
        .press  (press)
    );

    // Bring the run switch into the clock domain.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            run_1 <= 1'b0;
            run_s <= 1'b0;
        end else begin
            run_1 <= run_sw;
            run_s <= run_1;
        end
    end

    // Next state and pulse decision; halt beats switch beats breakpoint beats tick/press.
    always_comb begin
        state_nxt = state_q;
        ce_nxt    = 1'b0;
        if (state_q != HALTED && cpu.halted_in) begin
            state_nxt = HALTED;
        end else begin
            case (state_q)
                STOPPED: begin
                    if (run_s) begin
                        state_nxt = RUN;
                    end else if (press) begin
                        ce_nxt = 1'b1;
                    end
                end
                RUN: begin
                    if (!run_s) begin
                        state_nxt = STOPPED;
                    end else if (tick_q) begin
                        if (bp_en && cpu.pc == bp_addr) begin
                            state_nxt = BREAK;
                        end else begin
                            ce_nxt = 1'b1;
                        end
                    end
                end
                BREAK: begin
                    if (press) begin
                        ce_nxt    = 1'b1;
                        state_nxt = run_s ? RUN : STOPPED;
                    end
                end
                default: begin
                    state_nxt = state_q;
                end
            endcase
        end
    end

    assign stay_run = (state_q == RUN) && (state_nxt == RUN);

    // RUN divider. The wrap is registered as tick_q and acted on one cycle
    // later, so the first pulse lands DIV+1 cycles after entering RUN while
    // steady-state spacing stays DIV; any entry into RUN restarts from zero.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            div_q  <= '0;
            tick_q <= 1'b0;
        end else if (stay_run) begin
            div_q  <= (div_q == DIV_LAST) ? '0 : div_q + 1'b1;
            tick_q <= (div_q == DIV_LAST);
        end else begin
            div_q  <= '0;
            tick_q <= 1'b0;
        end
    end

    // Registered state, clock-enable pulse and saturating instruction count.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q      <= STOPPED;
            ce_q         <= 1'b0;
            step_count_q <= '0;
        end else begin
            state_q <= state_nxt;
            ce_q    <= ce_nxt;
            if (ce_nxt && step_count_q != '1) begin
                step_count_q <= step_count_q + 16'd1;
            end
        end
    end

    assign cpu.cpu_ce = ce_q;
    assign state      = state_q;
    assign step_count = step_count_q;

endmodule
